// File: rtl/csr_access_ctrl.sv
// CSR instruction sequencer: decodes CSRRW/RS/RC(I), reads then writes the CSR file port.
// Latency: 3 cycles read+write, 2 cycles read-only or write-only, 1 cycle illegal.
// Backpressure: one request in flight; response held in RESP until rsp_ready_i, req_ready_o low meanwhile.
module csr_access_ctrl #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [2:0]      funct3_i,
   input  logic [11:0]     csr_addr_i,
   input  logic [4:0]      rs1_idx_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [4:0]      rd_idx_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [XLEN-1:0] rsp_rdata_o,
   output logic            rsp_illegal_o,
   output logic            csr_rd_en_o,
   output logic            csr_wr_en_o,
   output logic [11:0]     csr_idx_o,
   output logic [XLEN-1:0] csr_wdata_o,
   input  logic [XLEN-1:0] csr_rdata_i
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   typedef struct packed {
      logic [2:0]      funct3;
      logic [11:0]     addr;
      logic [4:0]      rs1_idx;
      logic [XLEN-1:0] rs1_data;
      logic [4:0]      rd_idx;
   } req_t;

   typedef struct packed {
      logic ill;
      logic rd;
      logic wr;
   } dec_t;

   state_t          state_q;
   req_t            req_q;
   req_t            in_req;
   dec_t            in_dec;
   dec_t            q_dec;
   logic [XLEN-1:0] result_q;

   // funct3[1:0]==01 is the plain-write form; 00 covers both reserved encodings 000 and 100
   function automatic dec_t decode(input req_t r);
      dec_t d;
      d.wr  = (r.funct3[1:0] == 2'b01) || (r.rs1_idx != 5'd0);
      d.rd  = !((r.funct3[1:0] == 2'b01) && (r.rd_idx == 5'd0));
      d.ill = (r.funct3[1:0] == 2'b00) || (d.wr && (r.addr[11:10] == 2'b11));
      return d;
   endfunction

   function automatic logic [XLEN-1:0] src_of(input req_t r);
      return r.funct3[2] ? {{(XLEN-5){1'b0}}, r.rs1_idx} : r.rs1_data;
   endfunction

   function automatic logic [XLEN-1:0] wr_value(input logic [1:0] op,
                                                input logic [XLEN-1:0] old,
                                                input logic [XLEN-1:0] src);
      case (op)
         2'b01:   return src;
         2'b10:   return old | src;
         default: return old & ~src;
      endcase
   endfunction

   assign in_req = '{funct3: funct3_i, addr: csr_addr_i, rs1_idx: rs1_idx_i,
                     rs1_data: rs1_data_i, rd_idx: rd_idx_i};
   assign in_dec = decode(in_req);
   assign q_dec  = decode(req_q);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         req_q         <= '0;
         result_q      <= '0;
         req_ready_o   <= 1'b1;
         rsp_valid_o   <= 1'b0;
         rsp_rdata_o   <= '0;
         rsp_illegal_o <= 1'b0;
         csr_rd_en_o   <= 1'b0;
         csr_wr_en_o   <= 1'b0;
         csr_idx_o     <= '0;
         csr_wdata_o   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  req_q       <= in_req;
                  result_q    <= '0;
                  req_ready_o <= 1'b0;
                  if (in_dec.ill) begin
                     state_q       <= RESP;
                     rsp_valid_o   <= 1'b1;
                     rsp_illegal_o <= 1'b1;
                     rsp_rdata_o   <= '0;
                  end else if (in_dec.rd) begin
                     state_q     <= READ;
                     csr_rd_en_o <= 1'b1;
                     csr_idx_o   <= in_req.addr;
                  end else begin
                     // write-only: the "old" operand is zero
                     state_q     <= WRITE;
                     csr_wr_en_o <= 1'b1;
                     csr_idx_o   <= in_req.addr;
                     csr_wdata_o <= wr_value(in_req.funct3[1:0], '0, src_of(in_req));
                  end
               end
            end
            READ: begin
               csr_rd_en_o <= 1'b0;
               result_q    <= csr_rdata_i;
               if (q_dec.wr) begin
                  state_q     <= WRITE;
                  csr_wr_en_o <= 1'b1;
                  csr_wdata_o <= wr_value(req_q.funct3[1:0], csr_rdata_i, src_of(req_q));
               end else begin
                  state_q     <= RESP;
                  rsp_valid_o <= 1'b1;
                  rsp_rdata_o <= csr_rdata_i;
               end
            end
            WRITE: begin
               csr_wr_en_o <= 1'b0;
               state_q     <= RESP;
               rsp_valid_o <= 1'b1;
               rsp_rdata_o <= q_dec.rd ? result_q : '0;
            end
            RESP: begin
               if (rsp_ready_i) begin
                  state_q       <= IDLE;
                  req_ready_o   <= 1'b1;
                  rsp_valid_o   <= 1'b0;
                  rsp_rdata_o   <= '0;
                  rsp_illegal_o <= 1'b0;
                  csr_idx_o     <= '0;
                  csr_wdata_o   <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl: vector table plus backpressure and mid-write reset sequences.
// The CSR file is modelled as a single register answering reads at the address under test.
module tb_csr_access_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  funct3;
   logic [11:0] csr_addr;
   logic [4:0]  rs1_idx;
   logic [31:0] rs1_data;
   logic [4:0]  rd_idx;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_illegal;
   logic        csr_rd_en;
   logic        csr_wr_en;
   logic [11:0] csr_idx;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;

   logic [11:0] cur_addr;
   logic [31:0] cur_init;
   int          wr_edges;
   int          passed;
   int          total;

   csr_access_ctrl #(.XLEN(32)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .funct3_i(funct3), .csr_addr_i(csr_addr), .rs1_idx_i(rs1_idx),
      .rs1_data_i(rs1_data), .rd_idx_i(rd_idx),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_rdata_o(rsp_rdata), .rsp_illegal_o(rsp_illegal),
      .csr_rd_en_o(csr_rd_en), .csr_wr_en_o(csr_wr_en), .csr_idx_o(csr_idx),
      .csr_wdata_o(csr_wdata), .csr_rdata_i(csr_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign csr_rdata = (csr_rd_en && csr_idx == cur_addr) ? cur_init : 32'h0;

   always @(posedge clk) if (csr_wr_en) wr_edges <= wr_edges + 1;

   typedef struct {
      logic [2:0]  f3;
      logic [11:0] addr;
      logic [4:0]  rs1;
      logic [31:0] data;
      logic [4:0]  rd;
      logic [31:0] init;
      logic [31:0] e_rdata;
      logic        e_ill;
      int          e_lat;
      int          e_rd;
      int          e_wr;
      logic [31:0] e_wdata;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(input logic [2:0] f3, input logic [11:0] addr,
                               input logic [4:0] rs1, input logic [31:0] data,
                               input logic [4:0] rd, input logic [31:0] init,
                               input logic [31:0] e_rdata, input logic e_ill,
                               input int e_lat, input int e_rd, input int e_wr,
                               input logic [31:0] e_wdata);
      vec_t v;
      v.f3 = f3; v.addr = addr; v.rs1 = rs1; v.data = data; v.rd = rd; v.init = init;
      v.e_rdata = e_rdata; v.e_ill = e_ill; v.e_lat = e_lat;
      v.e_rd = e_rd; v.e_wr = e_wr; v.e_wdata = e_wdata;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge where rsp_valid is first seen.
   task automatic run_vec(input vec_t v, input int id);
      int lat, rd_cnt, wr_cnt;
      logic [31:0] wd;
      logic [11:0] wi;
      logic got;
      cur_addr = v.addr; cur_init = v.init;
      funct3 = v.f3; csr_addr = v.addr; rs1_idx = v.rs1; rs1_data = v.data; rd_idx = v.rd;
      req_valid = 1'b1;
      chk($sformatf("v%0d_req_ready", id), {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rs1_data = 32'hDEAD_BEEF; rs1_idx = 5'h1F; funct3 = 3'b000; csr_addr = 12'hFFF; rd_idx = 5'h0;
      lat = 0; rd_cnt = 0; wr_cnt = 0; wd = 32'h0; wi = 12'h0; got = 1'b0;
      while (!got && lat < 10) begin
         @(negedge clk);
         lat++;
         if (csr_rd_en) rd_cnt++;
         if (csr_wr_en) begin wr_cnt++; wd = csr_wdata; wi = csr_idx; end
         if (rsp_valid) got = 1'b1;
      end
      chk($sformatf("v%0d_latency", id), lat, v.e_lat);
      chk($sformatf("v%0d_rdata", id), rsp_rdata, v.e_rdata);
      chk($sformatf("v%0d_illegal", id), {31'b0, rsp_illegal}, {31'b0, v.e_ill});
      chk($sformatf("v%0d_rd_pulses", id), rd_cnt, v.e_rd);
      chk($sformatf("v%0d_wr_pulses", id), wr_cnt, v.e_wr);
      if (v.e_wr != 0) begin
         chk($sformatf("v%0d_wdata", id), wd, v.e_wdata);
         chk($sformatf("v%0d_wr_idx", id), {20'b0, wi}, {20'b0, v.addr});
      end
   endtask

   initial begin
      passed = 0; total = 0; wr_edges = 0;
      cur_addr = 12'h0; cur_init = 32'h0;
      rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
      funct3 = 3'b0; csr_addr = 12'h0; rs1_idx = 5'h0; rs1_data = 32'h0; rd_idx = 5'h0;

      //          f3      addr     rs1    data          rd     init          e_rdata       ill lat rd wr e_wdata
      vecs[0]  = mk(3'b001, 12'h305, 5'd1,  32'h8000_0100, 5'd5, 32'h0000_0000, 32'h0000_0000, 0, 3, 1, 1, 32'h8000_0100);
      vecs[1]  = mk(3'b010, 12'h300, 5'd0,  32'h1234_5678, 5'd1, 32'h0000_1888, 32'h0000_1888, 0, 2, 1, 0, 32'h0);
      vecs[2]  = mk(3'b011, 12'h304, 5'd2,  32'h0000_0808, 5'd3, 32'h0000_0888, 32'h0000_0888, 0, 3, 1, 1, 32'h0000_0080);
      vecs[3]  = mk(3'b101, 12'hF14, 5'd3,  32'h0,         5'd4, 32'h0000_0005, 32'h0,         1, 1, 0, 0, 32'h0);
      vecs[4]  = mk(3'b100, 12'h305, 5'd3,  32'h0,         5'd4, 32'h0000_0005, 32'h0,         1, 1, 0, 0, 32'h0);
      vecs[5]  = mk(3'b001, 12'h340, 5'd7,  32'h1234_5678, 5'd0, 32'h0000_AAAA, 32'h0,         0, 2, 0, 1, 32'h1234_5678);
      vecs[6]  = mk(3'b110, 12'h341, 5'd5,  32'h0,         5'd2, 32'h0000_0010, 32'h0000_0010, 0, 3, 1, 1, 32'h0000_0015);
      vecs[7]  = mk(3'b111, 12'h342, 5'h1F, 32'h0,         5'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 3, 1, 1, 32'hFFFF_FFE0);
      vecs[8]  = mk(3'b010, 12'hC00, 5'd0,  32'hFFFF_FFFF, 5'd6, 32'h0000_0077, 32'h0000_0077, 0, 2, 1, 0, 32'h0);
      vecs[9]  = mk(3'b010, 12'hC00, 5'd1,  32'hFFFF_FFFF, 5'd6, 32'h0000_0077, 32'h0,         1, 1, 0, 0, 32'h0);
      vecs[10] = mk(3'b000, 12'h300, 5'd1,  32'h1,         5'd6, 32'h0000_0077, 32'h0,         1, 1, 0, 0, 32'h0);
      vecs[11] = mk(3'b101, 12'h343, 5'h1A, 32'h0,         5'd0, 32'h0000_0009, 32'h0,         0, 2, 0, 1, 32'h0000_001A);

      repeat (2) @(negedge clk);
      chk("rst_req_ready",   {31'b0, req_ready},   32'd1);
      chk("rst_rsp_valid",   {31'b0, rsp_valid},   32'd0);
      chk("rst_rsp_illegal", {31'b0, rsp_illegal}, 32'd0);
      chk("rst_rsp_rdata",   rsp_rdata,            32'd0);
      chk("rst_rd_en",       {31'b0, csr_rd_en},   32'd0);
      chk("rst_wr_en",       {31'b0, csr_wr_en},   32'd0);
      chk("rst_csr_idx",     {20'b0, csr_idx},     32'd0);
      chk("rst_wdata",       csr_wdata,            32'd0);

      // release and present the first request on the same negedge
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         run_vec(vecs[i], i);
         @(negedge clk);
         chk($sformatf("v%0d_back_idle", i), {31'b0, req_ready}, 32'd1);
      end

      // response backpressure
      rsp_ready = 1'b0;
      run_vec(vecs[1], 20);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("bp%0d_valid", i),   {31'b0, rsp_valid}, 32'd1);
         chk($sformatf("bp%0d_rdata", i),   rsp_rdata,          32'h0000_1888);
         chk($sformatf("bp%0d_illegal", i), {31'b0, rsp_illegal}, 32'd0);
         chk($sformatf("bp%0d_req_ready", i), {31'b0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_idle_ready", {31'b0, req_ready}, 32'd1);
      chk("bp_idle_valid", {31'b0, rsp_valid}, 32'd0);

      // reset pulse in the middle of a CSRRW write cycle
      @(negedge clk);
      cur_addr = 12'h345; cur_init = 32'h55;
      funct3 = 3'b001; csr_addr = 12'h345; rs1_idx = 5'd4; rs1_data = 32'hAA; rd_idx = 5'd1;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("wrst_in_write", {31'b0, csr_wr_en}, 32'd1);
      chk("wrst_wdata", csr_wdata, 32'hAA);
      wr_edges = 0;
      #2 rst_n = 1'b0;
      #1;
      chk("wrst_wr_drop",    {31'b0, csr_wr_en}, 32'd0);
      chk("wrst_valid_drop", {31'b0, rsp_valid}, 32'd0);
      chk("wrst_ready",      {31'b0, req_ready}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("wrst_no_write", wr_edges, 32'd0);
      run_vec(mk(3'b110, 12'h344, 5'd1, 32'hFFFF_FFFF, 5'd9, 32'h0000_0100,
                 32'h0000_0100, 0, 3, 1, 1, 32'h0000_0101), 30);
      @(negedge clk);
      chk("final_idle", {31'b0, req_ready}, 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
